// File: rtl/idu_is_bju_resolve_ctrl.sv
// rtl/idu_is_bju_resolve_ctrl.sv - buffers BJU resolutions and retires the branch mask queue head in order
module idu_is_bju_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int IID_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_clk,
  input  logic                     rtu_global_flush,
  input  logic                     bju_res_vld,
  input  logic [IID_W-1:0]         bju_res_iid,
  input  logic                     bju_res_mispred,
  output logic                     bju_res_rdy,
  input  logic                     biq_head_vld,
  input  logic [IID_W-1:0]         biq_head_iid,
  output logic                     nojump,
  output logic                     bju_flush_req,
  output logic [IID_W-1:0]         bju_flush_iid,
  output logic [$clog2(DEPTH):0]   res_buf_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;

  logic [DEPTH-1:0]   buf_vld;
  logic [DEPTH-1:0]   buf_mispred;
  logic [IID_W-1:0]   buf_iid [DEPTH];

  logic               match_en;
  logic               accept;
  logic [DEPTH-1:0]   hit;
  logic               any_hit;
  logic               hit_mispred;
  logic [IDX_W-1:0]   hit_idx;
  logic [IID_W-1:0]   hit_iid;
  logic [IDX_W-1:0]   free_idx;

  // State register: RUN accepts and matches, FLUSH waits for the RTU global flush
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) state <= RUN;
    else         state <= state_nxt;
  end

  // Next state: the global flush always wins and returns to RUN
  always_comb begin
    state_nxt = state;
    if (rtu_global_flush)            state_nxt = RUN;
    else if (any_hit && hit_mispred) state_nxt = FLUSH;
  end

  // FSM outputs: readiness and match enable; the head is stale while nojump is high
  always_comb begin
    bju_res_rdy = (state == RUN) && (res_buf_cnt < FULL_CNT);
    match_en    = (state == RUN) && biq_head_vld && !nojump;
  end

  assign accept = bju_res_vld & bju_res_rdy;

  // Compare every buffered resolution against the mask queue head (iids are unique, so at most one hit)
  always_comb begin
    hit         = '0;
    any_hit     = 1'b0;
    hit_mispred = 1'b0;
    hit_idx     = '0;
    hit_iid     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = match_en && buf_vld[i] && (buf_iid[i] == biq_head_iid);
      if (hit[i]) begin
        any_hit     = 1'b1;
        hit_mispred = buf_mispred[i];
        hit_idx     = IDX_W'(i);
        hit_iid     = buf_iid[i];
      end
    end
  end

  // Lowest-index free slot receives the next accepted resolution
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!buf_vld[i]) free_idx = IDX_W'(i);
    end
  end

  // Buffer contents: hit clears its slot, accept fills a free one; global flush drops everything
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      buf_vld     <= '0;
      buf_mispred <= '0;
      for (int i = 0; i < DEPTH; i++) buf_iid[i] <= '0;
    end else if (rtu_global_flush) begin
      buf_vld <= '0;
    end else begin
      if (any_hit) buf_vld[hit_idx] <= 1'b0;
      if (accept) begin
        buf_vld[free_idx]     <= 1'b1;
        buf_iid[free_idx]     <= bju_res_iid;
        buf_mispred[free_idx] <= bju_res_mispred;
      end
    end
  end

  // Registered pop pulse, flush request and occupancy count
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      nojump        <= 1'b0;
      bju_flush_req <= 1'b0;
      bju_flush_iid <= '0;
      res_buf_cnt   <= '0;
    end else if (rtu_global_flush) begin
      nojump        <= 1'b0;
      bju_flush_req <= 1'b0;
      res_buf_cnt   <= '0;
    end else begin
      nojump <= any_hit && !hit_mispred;
      if (any_hit && hit_mispred) begin
        bju_flush_req <= 1'b1;
        bju_flush_iid <= hit_iid;
      end
      case ({accept, any_hit})
        2'b10:   res_buf_cnt <= res_buf_cnt + 1'b1;
        2'b01:   res_buf_cnt <= res_buf_cnt - 1'b1;
        default: res_buf_cnt <= res_buf_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_idu_is_bju_resolve_ctrl.sv
// tb/tb_idu_is_bju_resolve_ctrl.sv - directed and randomized bench for the BJU resolve controller
module tb_idu_is_bju_resolve_ctrl;

  localparam int DEPTH = 4;
  localparam int IID_W = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_clk = 1'b1;
  logic             rtu_global_flush = 1'b0;
  logic             bju_res_vld = 1'b0;
  logic [IID_W-1:0] bju_res_iid = '0;
  logic             bju_res_mispred = 1'b0;
  logic             bju_res_rdy;
  logic             biq_head_vld = 1'b0;
  logic [IID_W-1:0] biq_head_iid = '0;
  logic             nojump;
  logic             bju_flush_req;
  logic [IID_W-1:0] bju_flush_iid;
  logic [CW-1:0]    res_buf_cnt;

  idu_is_bju_resolve_ctrl #(.DEPTH(DEPTH), .IID_W(IID_W)) dut (
    .clk              (clk),
    .rst_clk          (rst_clk),
    .rtu_global_flush (rtu_global_flush),
    .bju_res_vld      (bju_res_vld),
    .bju_res_iid      (bju_res_iid),
    .bju_res_mispred  (bju_res_mispred),
    .bju_res_rdy      (bju_res_rdy),
    .biq_head_vld     (biq_head_vld),
    .biq_head_iid     (biq_head_iid),
    .nojump           (nojump),
    .bju_flush_req    (bju_flush_req),
    .bju_flush_iid    (bju_flush_iid),
    .res_buf_cnt      (res_buf_cnt)
  );

  always #5 clk = ~clk;

  // reference model: an unordered pool of outstanding resolutions plus mode flags
  typedef struct {
    logic [IID_W-1:0] iid;
    logic             mp;
  } res_t;

  res_t             m_buf[$];
  bit               m_run = 1'b1;
  bit               m_nojump = 1'b0;
  bit               m_freq = 1'b0;
  logic [IID_W-1:0] m_fiid = '0;
  bit               m_acc = 1'b0;

  // random-mode mask queue (program order) and bookkeeping
  bit               auto_mode = 1'b0;
  logic [IID_W-1:0] mq[$];
  bit               sent[32];
  logic [IID_W-1:0] next_iid = '0;
  int               pulses;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_rdy();
    return m_run && (m_buf.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_run = 1'b1; m_nojump = 1'b0; m_freq = 1'b0; m_fiid = '0; m_acc = 1'b0;
  endtask

  // advance the model by one clock using the inputs applied in the cycle just ended
  task automatic model_edge();
    bit acc, hit, mp;
    int hi;
    acc = bju_res_vld && m_rdy();
    hit = 1'b0; hi = 0; mp = 1'b0;
    if (m_run && biq_head_vld && !m_nojump)
      foreach (m_buf[i]) if (m_buf[i].iid == biq_head_iid) begin hit = 1'b1; hi = i; mp = m_buf[i].mp; end
    m_acc = acc && !rtu_global_flush;
    if (rtu_global_flush) begin
      m_buf.delete();
      m_nojump = 1'b0; m_freq = 1'b0; m_run = 1'b1;
    end else begin
      m_nojump = hit && !mp;
      if (hit && mp) begin m_freq = 1'b1; m_fiid = m_buf[hi].iid; m_run = 1'b0; end
      if (hit) m_buf.delete(hi);
      if (acc) m_buf.push_back('{iid: bju_res_iid, mp: bju_res_mispred});
    end
  endtask

  task automatic step();
    bit old_nj;
    @(posedge clk);
    old_nj = m_nojump;
    model_edge();
    if (auto_mode && old_nj && mq.size() > 0) begin
      sent[mq[0]] = 1'b0;
      void'(mq.pop_front());
    end
    #1;
    chk("nojump", int'(nojump), int'(m_nojump));
    chk("flush_req", int'(bju_flush_req), int'(m_freq));
    if (m_freq) chk("flush_iid", int'(bju_flush_iid), int'(m_fiid));
    chk("cnt", int'(res_buf_cnt), m_buf.size());
    chk("rdy", int'(bju_res_rdy), int'(m_rdy()));
    if (nojump) pulses++;
  endtask

  task automatic send(input logic [IID_W-1:0] iid, input logic mp);
    bju_res_vld = 1'b1; bju_res_iid = iid; bju_res_mispred = mp;
    step();
    bju_res_vld = 1'b0;
  endtask

  // random driver: mask queue advances on pops, resolutions come from the oldest DEPTH entries in any order
  task automatic drive();
    logic [IID_W-1:0] cand[$];
    if (rtu_global_flush) begin
      mq.delete();
      foreach (sent[i]) sent[i] = 1'b0;
      bju_res_vld = 1'b0;
    end else if (m_acc) begin
      sent[bju_res_iid] = 1'b1;
      bju_res_vld = 1'b0;
    end
    rtu_global_flush = 1'b0;
    if (!m_run && $urandom_range(0, 4) == 0)      rtu_global_flush = 1'b1;
    else if (m_run && $urandom_range(0, 199) == 0) rtu_global_flush = 1'b1;
    if (mq.size() < 8 && $urandom_range(0, 1) == 1) begin
      mq.push_back(next_iid);
      sent[next_iid] = 1'b0;
      next_iid++;
    end
    if (!bju_res_vld && $urandom_range(0, 2) != 0) begin
      for (int i = 0; i < mq.size() && i < DEPTH; i++) if (!sent[mq[i]]) cand.push_back(mq[i]);
      if (cand.size() > 0) begin
        bju_res_vld     = 1'b1;
        bju_res_iid     = cand[$urandom_range(0, cand.size() - 1)];
        bju_res_mispred = ($urandom_range(0, 15) == 0);
      end
    end
    biq_head_vld = (mq.size() > 0) && ($urandom_range(0, 7) != 0);
    biq_head_iid = (mq.size() > 0) ? mq[0] : IID_W'($urandom);
  endtask

  initial begin
    // power-on reset
    #2;
    chk("rst_nojump", int'(nojump), 0);
    chk("rst_freq", int'(bju_flush_req), 0);
    chk("rst_fiid", int'(bju_flush_iid), 0);
    chk("rst_cnt", int'(res_buf_cnt), 0);
    @(posedge clk); #1;
    rst_clk = 1'b0;
    chk("rst_rdy", int'(bju_res_rdy), 1);

    // asynchronous reset with two entries buffered
    send(5'd10, 1'b0);
    send(5'd11, 1'b0);
    chk("pre_rst_cnt", int'(res_buf_cnt), 2);
    #2 rst_clk = 1'b1;
    #1;
    chk("arst_nojump", int'(nojump), 0);
    chk("arst_freq", int'(bju_flush_req), 0);
    chk("arst_cnt", int'(res_buf_cnt), 0);
    model_reset();
    @(posedge clk); #1;
    rst_clk = 1'b0;
    step();
    chk("arst_rdy", int'(bju_res_rdy), 1);

    // in-order pop
    biq_head_vld = 1'b1; biq_head_iid = 5'd3;
    send(5'd3, 1'b0);
    chk("io_cnt_t1", int'(res_buf_cnt), 1);
    chk("io_nj_t1", int'(nojump), 0);
    step();
    chk("io_nj_t2", int'(nojump), 1);
    chk("io_cnt_t2", int'(res_buf_cnt), 0);
    biq_head_vld = 1'b0;
    step();
    chk("io_nj_t3", int'(nojump), 0);

    // out-of-order arrival
    pulses = 0;
    biq_head_vld = 1'b1; biq_head_iid = 5'd7;
    send(5'd9, 1'b0);
    send(5'd7, 1'b0);
    step();
    chk("ooo_nj_t3", int'(nojump), 1);
    biq_head_iid = 5'd9;
    step();
    chk("ooo_nj_t4", int'(nojump), 0);
    step();
    chk("ooo_nj_t5", int'(nojump), 1);
    biq_head_vld = 1'b0;
    step(); step();
    chk("ooo_pulses", pulses, 2);

    // full buffer with no matching head
    biq_head_vld = 1'b1; biq_head_iid = 5'd0;
    for (int k = 1; k <= 4; k++) send(5'(k), 1'b0);
    chk("full_cnt", int'(res_buf_cnt), 4);
    chk("full_rdy", int'(bju_res_rdy), 0);
    bju_res_vld = 1'b1; bju_res_iid = 5'd5; bju_res_mispred = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("full_hold_cnt", int'(res_buf_cnt), 4);
    biq_head_iid = 5'd1;
    step();
    chk("full_nj", int'(nojump), 1);
    chk("full_rdy_after", int'(bju_res_rdy), 1);
    biq_head_vld = 1'b0;
    step();
    bju_res_vld = 1'b0;
    rtu_global_flush = 1'b1;
    step();
    rtu_global_flush = 1'b0;
    chk("full_clr_cnt", int'(res_buf_cnt), 0);

    // mispredict and flush handshake
    biq_head_vld = 1'b1; biq_head_iid = 5'd4;
    send(5'd4, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mp_freq", int'(bju_flush_req), 1);
      chk("mp_fiid", int'(bju_flush_iid), 4);
      chk("mp_rdy", int'(bju_res_rdy), 0);
    end
    rtu_global_flush = 1'b1;
    step();
    rtu_global_flush = 1'b0;
    biq_head_vld = 1'b0;
    chk("mp_clr_freq", int'(bju_flush_req), 0);
    chk("mp_clr_cnt", int'(res_buf_cnt), 0);
    chk("mp_clr_rdy", int'(bju_res_rdy), 1);

    // global flush colliding with a hit and an accept
    biq_head_vld = 1'b1; biq_head_iid = 5'd6;
    send(5'd6, 1'b0);
    bju_res_vld = 1'b1; bju_res_iid = 5'd8; bju_res_mispred = 1'b0;
    rtu_global_flush = 1'b1;
    step();
    rtu_global_flush = 1'b0; bju_res_vld = 1'b0; biq_head_vld = 1'b0;
    chk("col_nj", int'(nojump), 0);
    chk("col_cnt", int'(res_buf_cnt), 0);
    chk("col_rdy", int'(bju_res_rdy), 1);
    step();
    chk("col_nj2", int'(nojump), 0);

    // randomized traffic against the model
    auto_mode = 1'b1;
    foreach (sent[i]) sent[i] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      drive();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
